// File: rtl/serializer_pkg.sv
// Shared constants for the per-lane serializer: word geometry and the idle symbol.
package serializer_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = $clog2(WORD_W);

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [7:0] IDLE_BYTE = 8'hBC;
    localparam word_t      IDLE_WORD = {4{IDLE_BYTE}};

endpackage

// File: rtl/lane_fifo2.sv
// Two-entry word FIFO feeding the serializer; push is ignored when full, pop when empty.
module lane_fifo2
    import serializer_pkg::*;
(
    input  logic  clk_32f,
    input  logic  reset,
    input  logic  push_i,
    input  word_t wdata_i,
    input  logic  pop_i,
    output word_t head_o,
    output logic  full_o,
    output logic  empty_o
);

    word_t      mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; the count guarantees a stale entry is never read out.
    always_ff @(posedge clk_32f) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/serializer_lane.sv
// Per-lane parallel-to-serial stage: 32-cycle back-to-back frames, each a buffered word or idle.
module serializer_lane
    import serializer_pkg::*;
(
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              active_out,
    output logic              word_done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            shreg_q, shreg_d;
    logic             data_q, data_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    word_t            head;
    word_t            load_word;
    logic             full, empty;
    logic             push, pop, load;

    assign ready_out = !full && !reset;
    assign push      = valid_in && ready_out;

    lane_fifo2 u_fifo (
        .clk_32f (clk_32f),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (data_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // NOTE: every signal gets a default first so no path leaves a value unassigned (no latch).
    always_comb begin
        load      = (cnt_q == CNT_W'(WORD_W - 1));
        pop       = load && !empty;
        load_word = empty ? IDLE_WORD : head;
        cnt_d     = cnt_q + CNT_W'(1);
        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
        data_d    = shreg_q[WORD_W-1];
        active_d  = active_q;
        done_d    = active_q && (cnt_q == CNT_W'(WORD_W - 2));
        if (load) begin
            // MSB goes straight out; the register keeps the remaining bits pre-shifted.
            cnt_d    = '0;
            shreg_d  = {load_word[WORD_W-2:0], 1'b0};
            data_d   = load_word[WORD_W-1];
            active_d = !empty;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            cnt_q    <= '1;
            shreg_q  <= '0;
            data_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign data_out   = data_q;
    assign active_out = active_q;
    assign word_done  = done_q;

endmodule

// File: tb/tb_serializer_lane.sv
// Self-checking bench for serializer_lane: frame-level vector table, corner sequences, random traffic.
module tb_serializer_lane;

    logic        clk_32f = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        data_out;
    logic        active_out;
    logic        word_done;

    localparam logic [31:0] IDLE_W = 32'hBCBC_BCBC;

    serializer_lane dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .active_out (active_out),
        .word_done  (word_done)
    );

    always #5 clk_32f = ~clk_32f;

    int nvec = 0;
    int nerr = 0;

    // Reference model: a queue of accepted words and the position within the current frame.
    logic [31:0] mq[$];
    int          pos = 0;
    int          edge_n = 0;
    logic [31:0] frame_w = 32'hBCBC_BCBC;
    bit          frame_data = 1'b0;
    bit          last_acc = 1'b0;
    logic        exp_dout = 1'b0;
    logic        exp_act = 1'b0;
    logic        exp_done = 1'b0;

    typedef struct {
        logic        push;
        int          push_edge;
        logic [31:0] word;
        logic [63:0] exp_bits;
        logic [63:0] exp_act;
        logic [63:0] exp_done;
    } vec_t;

    vec_t vtab[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [31:0] d);
        bit acc;
        if (r) begin
            mq.delete();
            pos        = 0;
            edge_n     = 0;
            frame_data = 1'b0;
            last_acc   = 1'b0;
            exp_dout   = 1'b0;
            exp_act    = 1'b0;
            exp_done   = 1'b0;
        end else begin
            acc = v && (mq.size() < 2);
            if (pos == 0) begin
                if (mq.size() > 0) begin
                    frame_w    = mq.pop_front();
                    frame_data = 1'b1;
                end else begin
                    frame_w    = IDLE_W;
                    frame_data = 1'b0;
                end
            end
            exp_dout = frame_w[31 - pos];
            exp_act  = frame_data;
            exp_done = frame_data && (pos == 31);
            if (acc) mq.push_back(d);
            last_acc = acc;
            pos      = (pos + 1) % 32;
            edge_n++;
        end
    endtask

    // One clock: drive inputs, check ready before the edge, check registered outputs after it.
    task automatic cycle(input logic r, input logic v, input logic [31:0] d);
        reset    = r;
        valid_in = v;
        data_in  = d;
        #1;
        check("ready_out", {63'd0, ready_out}, {63'd0, (!r && (mq.size() < 2))});
        @(posedge clk_32f);
        #1;
        model_edge(r, v, d);
        check("serial_outs", {61'd0, data_out, active_out, word_done},
              {61'd0, exp_dout, exp_act, exp_done});
    endtask

    task automatic reset_dut();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
    endtask

    // Offer three words, each held until accepted; returns the edge index where the third was taken.
    task automatic send3(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input int lead, input string tag, output int acc_e2);
        logic [31:0] ws[3];
        int          idx;
        int          e;
        ws     = '{w0, w1, w2};
        idx    = 0;
        acc_e2 = -1;
        reset_dut();
        repeat (lead) cycle(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 160; k++) begin
            if (idx < 3) begin
                e = edge_n;
                cycle(1'b0, 1'b1, ws[idx]);
                if (last_acc) begin
                    if (idx == 2) acc_e2 = e;
                    idx++;
                    if (idx == 2) check({tag, "_ready_low_when_full"}, {63'd0, ready_out}, 64'd0);
                end
            end else begin
                cycle(1'b0, 1'b0, 32'h0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_e2;
        int act_seen;

        vtab[0] = '{1'b1,  0, 32'hA5A5_A5A5, 64'hBCBCBCBC_A5A5A5A5, 64'h00000000_FFFFFFFF, 64'h1};
        vtab[1] = '{1'b1, 31, 32'h8000_0001, 64'hBCBCBCBC_80000001, 64'h00000000_FFFFFFFF, 64'h1};
        vtab[2] = '{1'b1, 15, 32'hFFFF_0000, 64'hBCBCBCBC_FFFF0000, 64'h00000000_FFFFFFFF, 64'h1};
        vtab[3] = '{1'b1,  1, 32'h0000_0000, 64'hBCBCBCBC_00000000, 64'h00000000_FFFFFFFF, 64'h1};
        vtab[4] = '{1'b1,  7, 32'hBCBC_BCBC, 64'hBCBCBCBC_BCBCBCBC, 64'h00000000_FFFFFFFF, 64'h1};
        vtab[5] = '{1'b0,  0, 32'h0000_0000, 64'hBCBCBCBC_BCBCBCBC, 64'h0,                 64'h0};

        // Frame-level table: one optional push in frame 0, capture edges E0..E63.
        for (int i = 0; i < 6; i++) begin
            logic [63:0] cb, ca, cd;
            cb = '0;
            ca = '0;
            cd = '0;
            reset_dut();
            for (int k = 0; k < 64; k++) begin
                if (vtab[i].push && k == vtab[i].push_edge) cycle(1'b0, 1'b1, vtab[i].word);
                else                                         cycle(1'b0, 1'b0, 32'h0);
                cb = {cb[62:0], data_out};
                ca = {ca[62:0], active_out};
                cd = {cd[62:0], word_done};
            end
            check($sformatf("tab%0d_bits", i), cb, vtab[i].exp_bits);
            check($sformatf("tab%0d_active", i), ca, vtab[i].exp_act);
            check($sformatf("tab%0d_word_done", i), cd, vtab[i].exp_done);
        end

        // Back-to-back from E0: third word enters the edge after the first pop (E32).
        send3(32'hFFFF_0000, 32'h0000_FFFF, 32'h1234_5678, 0, "b2b", acc_e2);
        check("b2b_third_accept_edge", 64'(acc_e2), 64'd33);

        // Full hold starting mid-frame: same acceptance point, order kept by the model.
        send3(32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_F00D, 10, "hold", acc_e2);
        check("hold_third_accept_edge", 64'(acc_e2), 64'd33);

        // Reset at cnt == 12 of a data frame with a second word buffered.
        reset_dut();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 32'h7777_7777);
        while (edge_n < 45) cycle(1'b0, 1'b0, 32'h0);
        check("pre_reset_active", {63'd0, active_out}, 64'd1);
        cycle(1'b1, 1'b0, 32'h0);
        check("mid_reset_outs", {61'd0, data_out, active_out, word_done}, 64'd0);
        act_seen = 0;
        for (int k = 0; k < 96; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (active_out || word_done) act_seen++;
        end
        check("post_reset_idle_only", 64'(act_seen), 64'd0);

        // Random traffic against the model, with occasional resets.
        reset_dut();
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
